// File: rtl/fir_coeff_pkg.sv
// Shared constants and state encoding for the FIR coefficient loader.
package fir_coeff_pkg;

  localparam int COEFF_W = 16;
  localparam int ADDR_W  = 4;
  localparam int NUM_W   = 6;

  localparam int NUM_TAPS_DEF   = 33;
  localparam int BANK_DEPTH_DEF = 10;
  localparam int IDLE_NUM_DEF   = 42;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FILL      = 3'd1;
  localparam logic [2:0] WAIT_SLOT = 3'd2;
  localparam logic [2:0] SETUP     = 3'd3;
  localparam logic [2:0] WRITE     = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Host-side coefficient stream: valid/ready handshake plus buffer clear.
interface fir_coeff_loader_if;
  import fir_coeff_pkg::*;

  logic                      iCoeffValid;
  logic signed [COEFF_W-1:0] iCoeffData;
  logic                      oCoeffReady;
  logic                      iClear;

  modport master (output iCoeffValid, output iCoeffData, output iClear, input oCoeffReady);
  modport slave  (input iCoeffValid, input iCoeffData, input iClear, output oCoeffReady);

endinterface

// File: rtl/fir_coeff_buf.sv
// Coefficient staging register file: one write port, one asynchronous read port.
module fir_coeff_buf
  import fir_coeff_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_DEF
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [NUM_W-1:0]          wr_idx,
  input  logic signed [COEFF_W-1:0] wr_data,
  input  logic [NUM_W-1:0]          rd_idx,
  output logic signed [COEFF_W-1:0] rd_data
);

  logic signed [COEFF_W-1:0] mem_q [NUM_TAPS];

  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx < NUM_W'(NUM_TAPS))) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = (rd_idx < NUM_W'(NUM_TAPS)) ? mem_q[rd_idx] : '0;

endmodule

// File: rtl/fir_coeff_loader.sv
// Collects NUM_TAPS host coefficients, then writes them to the FIR coefficient
// RAM as one burst aligned to the next sample-enable slot.
module fir_coeff_loader
  import fir_coeff_pkg::*;
#(
  parameter int NUM_TAPS   = NUM_TAPS_DEF,
  parameter int BANK_DEPTH = BANK_DEPTH_DEF,
  parameter int IDLE_NUM   = IDLE_NUM_DEF
) (
  input  logic                      iClk_12M,
  input  logic                      iRst,
  input  logic                      iEnSample_300k,
  fir_coeff_loader_if.slave         host,
  output logic                      oCoeffiUpdateFlag,
  output logic                      oCsnRam,
  output logic                      oWrnRam,
  output logic [ADDR_W-1:0]         oAddrRam,
  output logic signed [COEFF_W-1:0] oWrDtRam,
  output logic [NUM_W-1:0]          oNumOfCoeff,
  output logic                      oBusy,
  output logic                      oDone
);

  logic [2:0]                state_q, state_d;
  logic [NUM_W-1:0]          count_q, count_d;
  logic                      ready_q, ready_d;
  logic                      flag_q, flag_d;
  logic                      csn_q, csn_d;
  logic                      wrn_q, wrn_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic signed [COEFF_W-1:0] wrdt_q, wrdt_d;
  logic [NUM_W-1:0]          num_q, num_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      beat, clear, last_beat, last_write, in_burst_d;
  logic [NUM_W-1:0]          next_tap;
  logic signed [COEFF_W-1:0] rd_data;

  // ready_q is only high in IDLE/FILL, so a beat implies the fill phase
  assign beat       = host.iCoeffValid & ready_q;
  assign clear      = host.iClear & ((state_q == IDLE) || (state_q == FILL));
  assign last_beat  = beat && (count_q == NUM_W'(NUM_TAPS - 1));
  assign last_write = (num_q == NUM_W'(NUM_TAPS - 1));
  assign next_tap   = (state_q == SETUP) ? '0 : num_q + NUM_W'(1);

  fir_coeff_buf #(.NUM_TAPS(NUM_TAPS)) u_buf (
    .clk     (iClk_12M),
    .wr_en   (beat & ~clear),
    .wr_idx  (count_q),
    .wr_data (host.iCoeffData),
    .rd_idx  (next_tap),
    .rd_data (rd_data)
  );

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      flag_q  <= 1'b0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= '0;
      wrdt_q  <= '0;
      num_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= ready_d;
      flag_q  <= flag_d;
      csn_q   <= csn_d;
      wrn_q   <= wrn_d;
      addr_q  <= addr_d;
      wrdt_q  <= wrdt_d;
      num_q   <= num_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE, FILL: begin
        if (clear) begin
          state_d = IDLE;
          count_d = '0;
        end else if (beat) begin
          count_d = count_q + NUM_W'(1);
          state_d = last_beat ? WAIT_SLOT : FILL;
        end
      end
      WAIT_SLOT: if (iEnSample_300k) state_d = SETUP;
      SETUP:     state_d = WRITE;
      WRITE:     if (last_write) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q
  always_comb begin
    in_burst_d = (state_d == SETUP) || (state_d == WRITE);
    flag_d     = in_burst_d;
    csn_d      = ~in_burst_d;
    wrn_d      = ~in_burst_d;
    busy_d     = (state_d == WAIT_SLOT) || in_burst_d;
    done_d     = (state_d == DONE);
    ready_d    = (state_d == IDLE) || (state_d == FILL);
    addr_d     = addr_q;
    wrdt_d     = wrdt_q;
    num_d      = NUM_W'(IDLE_NUM);
    case (state_d)
      SETUP: begin
        num_d  = '0;
        addr_d = '0;
      end
      WRITE: begin
        num_d  = next_tap;
        wrdt_d = rd_data;
        if ((state_q == SETUP) || (addr_q == ADDR_W'(BANK_DEPTH))) addr_d = ADDR_W'(1);
        else addr_d = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  assign host.oCoeffReady = ready_q;
  assign oCoeffiUpdateFlag = flag_q;
  assign oCsnRam           = csn_q;
  assign oWrnRam           = wrn_q;
  assign oAddrRam          = addr_q;
  assign oWrDtRam          = wrdt_q;
  assign oNumOfCoeff       = num_q;
  assign oBusy             = busy_q;
  assign oDone             = done_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: fill, clear, slot wait, re-strobe,
// mid-burst reset and throttled host.
module tb_fir_coeff_loader;

  localparam int NT = 33;
  localparam int BD = 10;

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_data;
    logic [5:0]  exp_num;
    logic [3:0]  exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        flag, csn, wrn, busy, done;
  logic [3:0]  addr;
  logic [15:0] wrdt;
  logic [5:0]  num;

  vec_t        tbl [NT];
  logic [15:0] push_data [NT];
  logic [15:0] exp_data  [NT];
  int          tests = 0;
  int          fails = 0;
  int          cyc_out;
  int          bad;

  fir_coeff_loader_if host_if ();

  fir_coeff_loader dut (
    .iClk_12M          (clk),
    .iRst              (rst),
    .iEnSample_300k    (en),
    .host              (host_if.slave),
    .oCoeffiUpdateFlag (flag),
    .oCsnRam           (csn),
    .oWrnRam           (wrn),
    .oAddrRam          (addr),
    .oWrDtRam          (wrdt),
    .oNumOfCoeff       (num),
    .oBusy             (busy),
    .oDone             (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_pattern(input logic [15:0] base, input logic [15:0] step);
    for (int k = 0; k < NT; k++) begin
      push_data[k] = base + 16'(k) * step;
      exp_data[k]  = base + 16'(k) * step;
    end
  endtask

  task automatic push(input int n, input bit throttle, output int cycles);
    int sent;
    int cyc;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (throttle && (cyc % 2 == 0)) begin
        host_if.iCoeffValid = 1'b0;
      end else begin
        host_if.iCoeffValid = 1'b1;
        host_if.iCoeffData  = push_data[sent];
        if (host_if.oCoeffReady) sent++;
      end
    end
    @(negedge clk);
    host_if.iCoeffValid = 1'b0;
    cycles = cyc + 1;
    check("push_count", 64'(sent), 64'(n));
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {flag, csn, wrn, addr, wrdt, num, host_if.oCoeffReady, busy, done},
                {1'b0, 1'b1, 1'b1, 4'd0, 16'd0, 6'd0, 1'b0, 1'b0, 1'b0});
  endtask

  // Strobe once, then check SETUP, every WRITE beat and DONE.
  task automatic run_burst(input int restrobe_k, input int reset_k);
    int dones;
    dones = 0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("setup", {flag, csn, wrn, busy, num, addr}, {1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 4'd0});
    for (int k = 0; k < NT; k++) begin
      @(negedge clk);
      en = (k == restrobe_k);
      if (done) dones++;
      check($sformatf("write_k%0d", k), {flag, csn, wrn, busy, num, addr, wrdt},
            {1'b1, 1'b0, 1'b0, 1'b1, tbl[k].exp_num, tbl[k].exp_addr, exp_data[k]});
      if (k == reset_k) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("midburst_reset");
        repeat (3) begin
          @(negedge clk);
          if (done) dones++;
        end
        check("no_done_on_reset", 64'(dones), 64'd0);
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    en = 1'b0;
    check("done", {done, flag, csn, wrn, busy, num}, {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd42});
    if (done) dones++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("done_pulses", 64'(dones), 64'd1);
    check("idle_after_done", {host_if.oCoeffReady, busy, csn, num, addr, wrdt},
          {1'b1, 1'b0, 1'b1, 6'd42, tbl[NT-1].exp_addr, exp_data[NT-1]});
  endtask

  initial begin
    host_if.iCoeffValid = 1'b0;
    host_if.iCoeffData  = '0;
    host_if.iClear      = 1'b0;
    for (int k = 0; k < NT; k++) begin
      tbl[k].din      = 16'(k + 1);
      tbl[k].exp_data = 16'(k + 1);
      tbl[k].exp_num  = 6'(k);
      tbl[k].exp_addr = 4'((k % BD) + 1);
    end

    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {host_if.oCoeffReady, busy}, {1'b1, 1'b0});

    // Main burst: taps 0x0001..0x0021
    for (int k = 0; k < NT; k++) begin
      push_data[k] = tbl[k].din;
      exp_data[k]  = tbl[k].exp_data;
    end
    push(NT, 1'b0, cyc_out);
    check("wait_entry", {host_if.oCoeffReady, busy, csn}, {1'b0, 1'b1, 1'b1});
    run_burst(-1, -1);

    // Partial fill then clear; clear wins over a simultaneous beat
    set_pattern(16'h0100, 16'h0001);
    push(20, 1'b0, cyc_out);
    host_if.iClear      = 1'b1;
    host_if.iCoeffValid = 1'b1;
    host_if.iCoeffData  = 16'h5555;
    @(negedge clk);
    host_if.iClear      = 1'b0;
    host_if.iCoeffValid = 1'b0;
    check("ready_after_clear", {host_if.oCoeffReady, busy}, {1'b1, 1'b0});
    set_pattern(16'hFFF0, 16'h0000);
    push(NT, 1'b0, cyc_out);
    run_burst(-1, -1);

    // Long wait for the slot: host beats must not be consumed
    set_pattern(16'h8001, 16'h0101);
    push(NT, 1'b0, cyc_out);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      host_if.iCoeffValid = 1'b1;
      host_if.iCoeffData  = 16'h7FFF;
      if (!(busy && csn && !host_if.oCoeffReady && !flag)) bad++;
    end
    host_if.iCoeffValid = 1'b0;
    check("wait_slot_hold", 64'(bad), 64'd0);
    run_burst(-1, -1);

    // Re-strobe during WRITE must not stretch or restart the burst
    set_pattern(16'h0F00, 16'h0007);
    push(NT, 1'b0, cyc_out);
    run_burst(10, -1);

    // Reset at write k=15, then a fresh load
    set_pattern(16'h2000, 16'h0003);
    push(NT, 1'b0, cyc_out);
    run_burst(-1, 15);
    @(negedge clk);
    check("ready_after_midreset", {host_if.oCoeffReady, busy, done}, {1'b1, 1'b0, 1'b0});
    set_pattern(16'hC000, 16'h0111);
    push(NT, 1'b0, cyc_out);
    run_burst(-1, -1);

    // Throttled host: valid every other cycle
    set_pattern(16'h1000, 16'h0003);
    push(NT, 1'b1, cyc_out);
    check("throttle_fill_cycles", 64'(cyc_out), 64'd66);
    check("throttle_wait_entry", {host_if.oCoeffReady, busy}, {1'b0, 1'b1});
    run_burst(-1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
